// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: Avalon-MM read master that fetches the sysid ID and timestamp words,
// compares them with build-time values and reports pass/fail/timeout. Optional macro: SYSID_RECHECK_EN.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_ABCD,
  parameter logic [31:0] EXPECTED_TS    = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned AUTO_START     = 1,
  parameter int unsigned RECHECK_PERIOD = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic        fail_sticky
);

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 8;
  localparam int unsigned RW = 20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic          auto_q, auto_d;
  logic [DW-1:0] id_q, id_d, ts_q, ts_d;
  logic          id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, tmo_q, tmo_d;
  logic          read_q, read_d, addr_q, addr_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          id_match_c, ts_match_c;
  logic          abort_c, check_fail_c, recheck_c;

  assign tcnt_inc   = tcnt_q + TW'(1);
  assign id_match_c = (id_q == EXPECTED_ID);
  // A zero expected timestamp means the timestamp is not checked
  assign ts_match_c = (EXPECTED_TS == '0) || (ts_q == EXPECTED_TS);

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      auto_q  <= (AUTO_START != 0);
      id_q    <= '0;
      ts_q    <= '0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      tmo_q   <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      auto_q  <= auto_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      id_ok_q <= id_ok_d;
      ts_ok_q <= ts_ok_d;
      tmo_q   <= tmo_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    auto_d       = auto_q;
    id_d         = id_q;
    ts_d         = ts_q;
    id_ok_d      = id_ok_q;
    ts_ok_d      = ts_ok_q;
    tmo_d        = tmo_q;
    abort_c      = 1'b0;
    check_fail_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          state_d = RD_ID;
          auto_d  = 1'b0;
          tcnt_d  = '0;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          id_d    = avm_readdata;
          tcnt_d  = '0;
          state_d = RD_TS;
        end else if (tcnt_inc == TW'(TIMEOUT_CYCLES)) begin
          abort_c = 1'b1;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_d    = avm_readdata;
          tcnt_d  = '0;
          state_d = CHECK;
        end else if (tcnt_inc == TW'(TIMEOUT_CYCLES)) begin
          abort_c = 1'b1;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      CHECK: begin
        id_ok_d      = id_match_c;
        ts_ok_d      = ts_match_c;
        tmo_d        = 1'b0;
        check_fail_c = !(id_match_c && ts_match_c);
        state_d      = DONE;
      end
      DONE: begin
        if (start || recheck_c) begin
          state_d = RD_ID;
          tcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stalled too long: give up, keep whatever was captured so far
    if (abort_c) begin
      state_d = DONE;
      tcnt_d  = '0;
      tmo_d   = 1'b1;
      id_ok_d = 1'b0;
      ts_ok_d = 1'b0;
    end

    read_d = (state_d == RD_ID) || (state_d == RD_TS);
    addr_d = (state_d == RD_TS);
    busy_d = read_d || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

`ifdef SYSID_RECHECK_EN
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          sticky_q, sticky_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      rcnt_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      sticky_q <= sticky_d;
    end
  end

  // Re-check timer runs only while idle in DONE; leaving DONE clears it
  always_comb begin
    rcnt_d    = '0;
    recheck_c = 1'b0;
    sticky_d  = sticky_q | check_fail_c | abort_c;
    if (state_q == DONE) begin
      if (rcnt_q == RW'(RECHECK_PERIOD - 1)) begin
        recheck_c = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end
  end

  assign fail_sticky = sticky_q;
`else
  localparam int unsigned unused_recheck_period = RECHECK_PERIOD;
  logic unused_fail_evt;
  assign unused_fail_evt = check_fail_c | abort_c;
  assign recheck_c       = 1'b0;
  assign fail_sticky     = 1'b0;
`endif

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = tmo_q;

endmodule
